// File: rtl/lacpu_defs.sv
// rtl/lacpu_defs.sv - shared pipeline constants: bus widths, ALU op indices, bus field offsets
package lacpu_defs;

    localparam int DS_TO_ES_BUS_WD = 148;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_FWD_BUS_WD   = 39;

    localparam int ALU_OP_WD = 12;

    // One-hot ALU operation bit positions
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    // Decode-to-execute bus field offsets
    localparam int DS_PC_LSB      = 0;
    localparam int DS_RKD_LSB     = 32;
    localparam int DS_SRC2_LSB    = 64;
    localparam int DS_SRC1_LSB    = 96;
    localparam int DS_DEST_LSB    = 128;
    localparam int DS_GR_WE_BIT   = 133;
    localparam int DS_MEM_WE_BIT  = 134;
    localparam int DS_LOAD_OP_BIT = 135;
    localparam int DS_ALU_OP_LSB  = 136;

    // Execute-to-memory bus field offsets
    localparam int MS_PC_LSB      = 0;
    localparam int MS_RESULT_LSB  = 32;
    localparam int MS_DEST_LSB    = 64;
    localparam int MS_GR_WE_BIT   = 69;
    localparam int MS_RFM_BIT     = 70;

    // Forwarding bus field offsets
    localparam int FWD_RESULT_LSB = 0;
    localparam int FWD_DEST_LSB   = 32;
    localparam int FWD_LOAD_BIT   = 37;
    localparam int FWD_WE_BIT     = 38;

endpackage

// File: rtl/exe_stage_if.sv
// rtl/exe_stage_if.sv - decode/memory pipeline handshake and data SRAM request signals
interface exe_stage_if;
    import lacpu_defs::*;

    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus;
    logic                       data_sram_req;
    logic                       data_sram_wr;
    logic [3:0]                 data_sram_wstrb;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;
    logic                       data_sram_addr_ok;

    // Execute stage side
    modport master (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin, data_sram_addr_ok,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
        output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata
    );

    // Surrounding pipeline / memory side
    modport slave (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin, data_sram_addr_ok,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_bus,
        input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with one-hot operation select
module alu
    import lacpu_defs::*;
(
    input  logic [ALU_OP_WD-1:0] i_alu_op,
    input  logic [31:0]          i_src1,
    input  logic [31:0]          i_src2,
    output logic [31:0]          o_result
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [4:0]  w_sa;

    assign w_sum  = i_src1 + i_src2;
    assign w_diff = i_src1 - i_src2;
    assign w_sa   = i_src2[4:0];

    // OR together every selected operation; an all-zero op yields zero
    always_comb begin
        o_result = 32'h0;
        if (i_alu_op[OP_ADD])  o_result = o_result | w_sum;
        if (i_alu_op[OP_SUB])  o_result = o_result | w_diff;
        if (i_alu_op[OP_SLT])  o_result = o_result | {31'h0, $signed(i_src1) < $signed(i_src2)};
        if (i_alu_op[OP_SLTU]) o_result = o_result | {31'h0, i_src1 < i_src2};
        if (i_alu_op[OP_AND])  o_result = o_result | (i_src1 & i_src2);
        if (i_alu_op[OP_NOR])  o_result = o_result | ~(i_src1 | i_src2);
        if (i_alu_op[OP_OR])   o_result = o_result | (i_src1 | i_src2);
        if (i_alu_op[OP_XOR])  o_result = o_result | (i_src1 ^ i_src2);
        if (i_alu_op[OP_SLL])  o_result = o_result | (i_src1 << w_sa);
        if (i_alu_op[OP_SRL])  o_result = o_result | (i_src1 >> w_sa);
        if (i_alu_op[OP_SRA])  o_result = o_result | 32'($signed(i_src1) >>> w_sa);
        if (i_alu_op[OP_LUI])  o_result = o_result | i_src2;
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, data SRAM request issue, forwarding bus
module exe_stage
    import lacpu_defs::*;
(
    input  logic         clk,
    input  logic         resetn,
    exe_stage_if.master  bus
);

    logic                       r_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] r_es_bus;
    logic                       r_addr_acked;

    logic [ALU_OP_WD-1:0] w_alu_op;
    logic                 w_load_op;
    logic                 w_mem_we;
    logic                 w_gr_we;
    logic [4:0]           w_dest;
    logic [31:0]          w_src1;
    logic [31:0]          w_src2;
    logic [31:0]          w_rkd_value;
    logic [31:0]          w_pc;
    logic [31:0]          w_alu_result;
    logic                 w_mem_op;
    logic                 w_req;
    logic                 w_addr_hs;
    logic                 w_ready_go;
    logic                 w_allowin;
    logic                 w_depart;

    assign w_alu_op    = r_es_bus[DS_ALU_OP_LSB +: ALU_OP_WD];
    assign w_load_op   = r_es_bus[DS_LOAD_OP_BIT];
    assign w_mem_we    = r_es_bus[DS_MEM_WE_BIT];
    assign w_gr_we     = r_es_bus[DS_GR_WE_BIT];
    assign w_dest      = r_es_bus[DS_DEST_LSB +: 5];
    assign w_src1      = r_es_bus[DS_SRC1_LSB +: 32];
    assign w_src2      = r_es_bus[DS_SRC2_LSB +: 32];
    assign w_rkd_value = r_es_bus[DS_RKD_LSB +: 32];
    assign w_pc        = r_es_bus[DS_PC_LSB +: 32];

    alu u_alu (
        .i_alu_op (w_alu_op),
        .i_src1   (w_src1),
        .i_src2   (w_src2),
        .o_result (w_alu_result)
    );

    // A memory op may only leave once its address has been accepted,
    // either earlier (acked) or in this very cycle (addr_ok completes it combinationally)
    assign w_mem_op   = w_load_op | w_mem_we;
    assign w_req      = r_es_valid & w_mem_op & ~r_addr_acked;
    assign w_addr_hs  = w_req & bus.data_sram_addr_ok;
    assign w_ready_go = ~w_mem_op | r_addr_acked | w_addr_hs;
    assign w_depart   = w_ready_go & bus.ms_allowin;
    assign w_allowin  = ~r_es_valid | w_depart;

    // Stage occupancy follows decode whenever the slot is free or emptying
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        r_es_valid <= 1'b0;
        else if (w_allowin) r_es_valid <= bus.ds_to_es_valid;
    end

    // Capture the decode bus only for a real incoming instruction; bubbles keep the old contents
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                               r_es_bus <= '0;
        else if (w_allowin && bus.ds_to_es_valid)  r_es_bus <= bus.ds_to_es_bus;
    end

    // Remember an accepted request while memory stage stalls so it is never re-issued
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            r_addr_acked <= 1'b0;
        else if (w_depart)                      r_addr_acked <= 1'b0;
        else if (w_addr_hs && !bus.ms_allowin)  r_addr_acked <= 1'b1;
    end

    assign bus.es_allowin     = w_allowin;
    assign bus.es_to_ms_valid = r_es_valid & w_ready_go;
    assign bus.es_to_ms_bus   = {w_load_op, w_gr_we, w_dest, w_alu_result, w_pc};
    assign bus.es_fwd_bus     = {r_es_valid & w_gr_we, r_es_valid & w_load_op, w_dest, w_alu_result};

    // Word accesses only: the low two address bits are dropped
    assign bus.data_sram_req   = w_req;
    assign bus.data_sram_wr    = w_mem_we;
    assign bus.data_sram_wstrb = w_mem_we ? 4'hf : 4'h0;
    assign bus.data_sram_addr  = {w_alu_result[31:2], 2'b00};
    assign bus.data_sram_wdata = w_rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage
module tb_exe_stage;

    logic clk;
    logic resetn;
    int   tests;
    int   fails;
    int   cycle;
    int   hs_count;
    int   last_dep;
    int   prev_dep;

    logic [70:0] exp_q[$];
    logic [68:0] sram_q[$];

    exe_stage_if u_if();

    exe_stage u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [147:0] mk_ds(input logic [11:0] op, input logic ld, input logic we,
                                           input logic gw, input logic [4:0] dest,
                                           input logic [31:0] s1, input logic [31:0] s2,
                                           input logic [31:0] rkd, input logic [31:0] pc);
        return {op, ld, we, gw, dest, s1, s2, rkd, pc};
    endfunction

    function automatic logic [70:0] mk_ms(input logic rfm, input logic gw, input logic [4:0] dest,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {rfm, gw, dest, res, pc};
    endfunction

    // Present an instruction until the stage takes it; called and returns at posedge+1
    task automatic issue(input logic [147:0] b);
        logic acc;
        u_if.ds_to_es_valid = 1'b1;
        u_if.ds_to_es_bus   = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = u_if.es_allowin;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        tests++;
        fails++;
        $display("FAIL issue_timeout: got no allowin expected allowin within 50 cycles");
    endtask

    // Monitor: pop and compare on every accepted request and every departure
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && u_if.data_sram_req && u_if.data_sram_addr_ok) begin
                hs_count++;
                if (sram_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sram_unexpected: got addr %0h expected no request", u_if.data_sram_addr);
                end else begin
                    check("sram_req", {u_if.data_sram_wr, u_if.data_sram_wstrb,
                                       u_if.data_sram_addr, u_if.data_sram_wdata}, sram_q.pop_front());
                end
            end
            if (resetn && u_if.es_to_ms_valid && u_if.ms_allowin) begin
                prev_dep = last_dep;
                last_dep = cycle;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dep_unexpected: got bus %0h expected no departure", u_if.es_to_ms_bus);
                end else begin
                    check("es_to_ms_bus", u_if.es_to_ms_bus, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [147:0] b;
        int hs0;
        tests = 0; fails = 0; cycle = 0; hs_count = 0; last_dep = 0; prev_dep = 0;
        resetn = 1'b0;
        u_if.ds_to_es_valid    = 1'b0;
        u_if.ds_to_es_bus      = '0;
        u_if.ms_allowin        = 1'b1;
        u_if.data_sram_addr_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_to_ms_valid", u_if.es_to_ms_valid, 0);
        check("rst_req", u_if.data_sram_req, 0);
        check("rst_allowin", u_if.es_allowin, 1);
        check("rst_fwd_bus", u_if.es_fwd_bus, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // add 5+7 -> 12
        exp_q.push_back(mk_ms(0, 1, 3, 32'd12, 32'h1c000000));
        issue(mk_ds(12'h001, 0, 0, 1, 3, 32'd5, 32'd7, 32'h0, 32'h1c000000));
        u_if.ds_to_es_valid = 1'b0;
        check("add_valid", u_if.es_to_ms_valid, 1);
        check("add_fwd", u_if.es_fwd_bus, {1'b1, 1'b0, 5'd3, 32'd12});
        @(posedge clk); #1;

        // store, addr_ok immediate
        u_if.data_sram_addr_ok = 1'b1;
        exp_q.push_back(mk_ms(0, 0, 0, 32'h1006, 32'h1c000004));
        sram_q.push_back({1'b1, 4'hf, 32'h1004, 32'hDEADBEEF});
        issue(mk_ds(12'h001, 0, 1, 0, 0, 32'h1000, 32'h6, 32'hDEADBEEF, 32'h1c000004));
        u_if.ds_to_es_valid = 1'b0;
        check("st_req", u_if.data_sram_req, 1);
        check("st_valid", u_if.es_to_ms_valid, 1);
        @(posedge clk); #1;

        // load with addr_ok delayed 3 cycles
        u_if.data_sram_addr_ok = 1'b0;
        exp_q.push_back(mk_ms(1, 1, 5, 32'h2010, 32'h1c000008));
        sram_q.push_back({1'b0, 4'h0, 32'h2010, 32'h11111111});
        issue(mk_ds(12'h001, 1, 0, 1, 5, 32'h2000, 32'h10, 32'h11111111, 32'h1c000008));
        u_if.ds_to_es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_wait_req", u_if.data_sram_req, 1);
            check("ld_wait_addr", u_if.data_sram_addr, 32'h2010);
            check("ld_wait_allowin", u_if.es_allowin, 0);
            check("ld_wait_valid", u_if.es_to_ms_valid, 0);
            @(posedge clk); #1;
        end
        u_if.data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("ld_done_valid", u_if.es_to_ms_valid, 1);
        @(posedge clk); #1;

        // load accepted while memory stage stalls for 2 cycles
        u_if.ms_allowin = 1'b0;
        hs0 = hs_count;
        exp_q.push_back(mk_ms(1, 1, 6, 32'h3004, 32'h1c00000c));
        sram_q.push_back({1'b0, 4'h0, 32'h3004, 32'h22222222});
        issue(mk_ds(12'h001, 1, 0, 1, 6, 32'h3000, 32'h4, 32'h22222222, 32'h1c00000c));
        u_if.ds_to_es_valid = 1'b0;
        check("lds_req_first", u_if.data_sram_req, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("lds_req_dropped", u_if.data_sram_req, 0);
        check("lds_valid_held", u_if.es_to_ms_valid, 1);
        check("lds_allowin", u_if.es_allowin, 0);
        @(posedge clk); #1;
        u_if.ms_allowin = 1'b1;
        @(posedge clk); #1;
        check("lds_one_request", hs_count - hs0, 1);
        check("lds_left", u_if.es_to_ms_valid, 0);
        u_if.data_sram_addr_ok = 1'b0;

        // back-to-back slt / sltu
        exp_q.push_back(mk_ms(0, 1, 7, 32'd1, 32'h1c000010));
        exp_q.push_back(mk_ms(0, 1, 8, 32'd0, 32'h1c000014));
        issue(mk_ds(12'h004, 0, 0, 1, 7, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h1c000010));
        issue(mk_ds(12'h008, 0, 0, 1, 8, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h1c000014));
        u_if.ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
        check("slt_no_bubble", last_dep - prev_dep, 1);

        // xor
        exp_q.push_back(mk_ms(0, 1, 9, 32'hFF00FF00, 32'h1c000018));
        issue(mk_ds(12'h080, 0, 0, 1, 9, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h1c000018));
        u_if.ds_to_es_valid = 1'b0;
        @(posedge clk); #1;

        // asynchronous reset during a stalled load
        b = mk_ds(12'h001, 1, 0, 1, 10, 32'h4000, 32'h8, 32'h0, 32'h1c00001c);
        exp_q.push_back(mk_ms(1, 1, 10, 32'h4008, 32'h1c00001c));
        sram_q.push_back({1'b0, 4'h0, 32'h4008, 32'h0});
        issue(b);
        u_if.ds_to_es_valid = 1'b0;
        check("arst_pre_req", u_if.data_sram_req, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_req", u_if.data_sram_req, 0);
        check("arst_valid", u_if.es_to_ms_valid, 0);
        check("arst_allowin", u_if.es_allowin, 1);
        check("arst_fwd_we", u_if.es_fwd_bus[38], 0);
        void'(exp_q.pop_back());
        void'(sram_q.pop_back());
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // recovery after reset
        exp_q.push_back(mk_ms(0, 1, 11, 32'd123, 32'h1c000020));
        issue(mk_ds(12'h001, 0, 0, 1, 11, 32'd100, 32'd23, 32'h0, 32'h1c000020));
        u_if.ds_to_es_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("sram_q_drained", sram_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage in-order pipeline, between decode and memory. It latches the decode-to-execute bus under a valid/allowin handshake and drives the `alu` combinational unit. It issues the data-SRAM request for loads and stores over a req/addr_ok handshake, then hands the result bus to the memory stage. It also exports a forwarding/hazard bus to decode.

## Interface
Parameters:
- `DS_TO_ES_BUS_WD`, 148: decode→execute bus width.
- `ES_TO_MS_BUS_WD`, 71: execute→memory bus width.
- `ES_FWD_BUS_WD`, 39: forwarding bus width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ds_to_es_valid` in 1: decode holds a valid instruction.
- `ds_to_es_bus` in 148: bit layout MSB→LSB:
  - `alu_op`[147:136]
  - `load_op`[135]
  - `mem_we`[134]
  - `gr_we`[133]
  - `dest`[132:128]
  - `src1`[127:96]
  - `src2`[95:64]
  - `rkd_value`[63:32]
  - `pc`[31:0]
- `es_allowin` out 1: stage can accept this cycle.
- `ms_allowin` in 1: memory stage can accept.
- `es_to_ms_valid` out 1: valid instruction ready to leave.
- `es_to_ms_bus` out 71: bit layout MSB→LSB:
  - `res_from_mem`[70]
  - `gr_we`[69]
  - `dest`[68:64]
  - `alu_result`[63:32]
  - `pc`[31:0]
- `es_fwd_bus` out 39: bit layout MSB→LSB:
  - `fwd_we`[38], equal to `es_valid & gr_we`
  - `is_load`[37]
  - `dest`[36:32]
  - `alu_result`[31:0]
- `data_sram_req` out 1: memory request.
- `data_sram_wr` out 1: 1 = store.
- `data_sram_wstrb` out 4: byte enables.
- `data_sram_addr` out 32: request address.
- `data_sram_wdata` out 32: store data.
- `data_sram_addr_ok` in 1: request accepted this cycle.

## Operation
Internal state:
- `es_valid` register.
- Latched bus register `es_bus_r`.
- `addr_acked` flag.

ALU and memory decode:
- `alu` is instantiated on the latched `alu_op`/`src1`/`src2`. `alu_result` is forwarded unmodified.
- `mem_op` = `load_op | mem_we`. Word accesses only.
- `data_sram_addr` = {`alu_result`[31:2], 2'b00}. Low address bits are ignored.
- `data_sram_wdata` = `rkd_value`.
- `data_sram_wr` = `mem_we`.
- `data_sram_wstrb` = `mem_we` ? 4'hf : 4'h0.

Request handshake:
- `data_sram_req` = `es_valid & mem_op & ~addr_acked`.
- `addr_hs` = `data_sram_req & data_sram_addr_ok`.
- `es_ready_go` = `~mem_op | addr_acked | addr_hs`.

Pipeline handshake:
- `es_allowin` = `~es_valid | (es_ready_go & ms_allowin)`.
- `es_to_ms_valid` = `es_valid & es_ready_go`.
- On `es_allowin`: `es_valid` ← `ds_to_es_valid`.
- On `es_allowin & ds_to_es_valid`: `es_bus_r` ← `ds_to_es_bus`. Otherwise `es_bus_r` holds.

`addr_acked` update:
- Set on `addr_hs & ~ms_allowin`: accepted, but the instruction cannot leave yet.
- Cleared whenever `es_ready_go & ms_allowin`, i.e. the instruction departs.
- Never re-issue a request for an acknowledged instruction.

Output bus fields:
- `res_from_mem` = `load_op`.
- `is_load` = `es_valid & load_op`.

## Timing
- Reset (asynchronous assert):
  - `es_valid`=0, `addr_acked`=0, `es_bus_r`=0.
  - Hence `es_to_ms_valid`=0, `data_sram_req`=0, `es_allowin`=1, `fwd_we`=0.
  - Deassertion takes effect at the next edge.
- Non-memory latency: 1 cycle; the result leaves the cycle after capture if `ms_allowin`=1.
- Memory latency: at least 1 cycle; the instruction waits until `addr_ok`.
- `addr_ok` combinationally completes `es_ready_go` in the same cycle.
- Request hold: while `data_sram_req`=1 without `addr_ok`, the request fields are stable and `es_allowin`=0.
- `addr_ok` with `ms_allowin`=0: `addr_acked` is set, `req` drops next cycle, and the stage holds until `ms_allowin`.
- Simultaneous departure and arrival: a new instruction is captured in the same edge; `addr_acked` clears.
- `ds_to_es_valid`=0 while `es_allowin`=1: bubble, `es_valid`→0.
- `addr_ok` while `req`=0: ignored.
- Reset mid-request: the outstanding request is dropped; the memory side tolerates this.

## Structure
- Shared package `lacpu_defs` holds:
  - The three bus width constants.
  - ALU op bit indices: add 0, sub 1, slt 2, sltu 3, and 4, nor 5, or 6, xor 7, sll 8, srl 9, sra 10, lui 11.
  - Bus field offsets.
- Sub-module: the existing `alu`, one instance. No other sub-modules.

## Test plan
- **Reset then add:** `ds_to_es_valid`=1, `alu_op`=0x001, `src1`=5, `src2`=7, `gr_we`=1, `dest`=3, `ms_allowin`=1 → next cycle `es_to_ms_valid`=1, `alu_result`=12, `es_fwd_bus`={1,0,3,12}.
- **Store with immediate `addr_ok`:**
  - Stimulus: `mem_we`=1, `alu_op` add, `src1`=0x1000, `src2`=0x6, `rkd_value`=0xDEADBEEF, `addr_ok`=1.
  - Response: `req`=1, `addr`=0x1004, `wstrb`=0xf, `wdata`=0xDEADBEEF; the instruction leaves the same cycle with `res_from_mem`=0.
- **Load with `addr_ok` delayed 3 cycles:** `req` is held with a stable `addr` for 3 cycles and `es_allowin`=0; on the 4th cycle the handshake completes, `es_to_ms_valid`=1 and `res_from_mem`=1.
- **Load accepted while `ms_allowin`=0 for 2 cycles:** `req` drops after the handshake (exactly one accepted request); the stage leaves when `ms_allowin` rises.
- **Back-to-back `slt`/`sltu`:**
  - `slt` with `src1`=0xFFFFFFFF, `src2`=1 → result 1.
  - `sltu` with the same operands → result 0.
  - No bubble between them.
- **Asynchronous reset pulse during a stalled load:** `es_valid`, `req` and `es_to_ms_valid` go 0 immediately, independent of `clk`; `es_allowin`=1.
